// File: rtl/pulse_meas_pkg.sv
// Shared types and defaults for the pulse width meter.
package pulse_meas_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS_HIGH,
    MEAS_LOW
  } state_e;

endpackage

// File: rtl/edge_detect.sv
// Two-stage sample of a same-clock waveform; provides the sampled level and a
// one-cycle rising-edge strobe derived from the two stages.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1_q, s1_d;
  logic s0_q, s0_d;

  always_comb begin
    s1_d = din;
    s0_d = s1_q;
  end

  // NOTE: non-blocking assignments make s0 capture the previous s1, not the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s0_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s0_q <= s0_d;
    end
  end

  assign level = s1_q;
  assign rise  = s1_q & ~s0_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high time and period of a same-clock waveform, publishing each
// completed period through a single-entry valid/ready result register.
module pulse_width_meter
  import pulse_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             meas_en,
  output logic [CNT_W-1:0] res_high,
  output logic [CNT_W-1:0] res_period,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic level, rise;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .level(level),
    .rise (rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] res_high_q, res_high_d;
  logic [CNT_W-1:0] res_period_q, res_period_d;
  logic             res_valid_q, res_valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             publish;
  logic             accept;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    publish      = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        if (meas_en) state_d = ARM;
      end
      ARM: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        if (rise) begin
          state_d      = MEAS_HIGH;
          period_cnt_d = ONE;
          high_cnt_d   = ONE;
        end
      end
      MEAS_HIGH: begin
        if (period_cnt_q == MAX_CNT) begin
          timeout_d    = 1'b1;
          state_d      = ARM;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end else begin
          period_cnt_d = period_cnt_q + ONE;
          if (level) high_cnt_d = high_cnt_q + ONE;
          else       state_d    = MEAS_LOW;
        end
      end
      MEAS_LOW: begin
        // The closing rise wins over a timeout on the same cycle.
        if (rise) begin
          publish      = 1'b1;
          state_d      = MEAS_HIGH;
          period_cnt_d = ONE;
          high_cnt_d   = ONE;
        end else if (period_cnt_q == MAX_CNT) begin
          timeout_d    = 1'b1;
          state_d      = ARM;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end else begin
          period_cnt_d = period_cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!meas_en) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      publish      = 1'b0;
      timeout_d    = 1'b0;
    end
  end

  always_comb begin
    accept       = res_valid_q & res_ready;
    res_high_d   = res_high_q;
    res_period_d = res_period_q;
    if (publish) begin
      res_high_d   = high_cnt_q;
      res_period_d = period_cnt_q;
    end
    res_valid_d = publish | (res_valid_q & ~res_ready);

    overrun_d = overrun_q;
    if (accept) overrun_d = 1'b0;
    if (publish && res_valid_q && !res_ready) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      res_high_q   <= '0;
      res_period_q <= '0;
      res_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      res_high_q   <= res_high_d;
      res_period_q <= res_period_d;
      res_valid_q  <= res_valid_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign res_high   = res_high_q;
  assign res_period = res_period_q;
  assign res_valid  = res_valid_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed self-checking bench for pulse_width_meter.
module tb_pulse_width_meter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             meas_en;
  logic [CNT_W-1:0] res_high;
  logic [CNT_W-1:0] res_period;
  logic             res_valid;
  logic             res_ready;
  logic             overrun;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  // Monitor-owned counters; the stimulus takes snapshots and compares deltas.
  int  pub_cnt = 0;
  int  min_cnt = 0;
  int  to_cnt  = 0;
  int  run     = 0;
  int  max_run = 0;
  logic track_run = 1'b0;

  pulse_width_meter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .meas_en   (meas_en),
    .res_high  (res_high),
    .res_period(res_period),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (timeout === 1'b1) to_cnt <= to_cnt + 1;
    if (res_valid === 1'b1) begin
      pub_cnt <= pub_cnt + 1;
      if (res_high == 16'd1 && res_period == 16'd2) min_cnt <= min_cnt + 1;
      if (track_run) begin
        run <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
      end
    end else begin
      run <= 0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hi >= 3. When chk is set the rise that opens this period also closes the
  // previous one, whose result must appear exactly two ticks later as a pulse.
  task automatic wave(input int hi, input int lo, input bit chk, input int eh, input int ep);
    din = 1'b1;
    tick();
    if (chk) check("latency_pre", int'(res_valid), 0);
    tick();
    if (chk) begin
      check("pub_valid", int'(res_valid), 1);
      check("pub_high", int'(res_high), eh);
      check("pub_period", int'(res_period), ep);
    end
    tick();
    if (chk) check("pub_pulse", int'(res_valid), 0);
    repeat (hi - 3) tick();
    din = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(res_valid), 0);
    check({tag, "_high"}, int'(res_high), 0);
    check({tag, "_period"}, int'(res_period), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    int pub_base, min_base, to_base;

    // Reset with the input toggling.
    rst = 1'b1; meas_en = 1'b0; res_ready = 1'b0; din = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      tick();
    end
    check_all_zero("reset");

    // Idle: toggling input while disabled never produces a result.
    rst = 1'b0;
    pub_base = pub_cnt;
    for (int i = 0; i < 6; i++) begin
      din = ~din;
      tick();
    end
    din = 1'b0;
    tick();
    check("idle_valid", int'(res_valid), 0);
    check("idle_pubs", pub_cnt - pub_base, 0);

    // Nominal 401/400 waveform, then 3/5 duty, then 1/1 minimum.
    meas_en = 1'b1; res_ready = 1'b1;
    tick(); tick();
    pub_base = pub_cnt; min_base = min_cnt; track_run = 1'b1;
    wave(401, 400, 1'b0, 0, 0);
    wave(401, 400, 1'b1, 401, 801);
    wave(401, 400, 1'b1, 401, 801);
    wave(3, 5, 1'b1, 401, 801);
    wave(3, 5, 1'b1, 3, 8);
    for (int i = 0; i < 10; i++) begin
      din = 1'b1; tick();
      din = 1'b0; tick();
    end
    tick();
    track_run = 1'b0;
    check("nominal_pubs", pub_cnt - pub_base, 14);
    check("min_pubs", min_cnt - min_base, 9);
    check("valid_max_run", max_run, 1);

    // Backpressure: two publishes without ready overwrite and flag overrun.
    res_ready = 1'b0;
    din = 1'b1; tick(); tick();
    check("bp_first_valid", int'(res_valid), 1);
    check("bp_first_overrun", int'(overrun), 0);
    din = 1'b0; tick(); tick();
    din = 1'b1; tick(); tick();
    check("bp_ovr_valid", int'(res_valid), 1);
    check("bp_ovr_flag", int'(overrun), 1);
    check("bp_ovr_high", int'(res_high), 2);
    check("bp_ovr_period", int'(res_period), 4);
    res_ready = 1'b1; tick();
    check("bp_accept_valid", int'(res_valid), 0);
    check("bp_accept_overrun", int'(overrun), 0);

    // Publish in the same cycle as an accept: new data, no overrun.
    res_ready = 1'b0;
    din = 1'b0; tick(); tick();
    din = 1'b1; tick(); tick();
    check("pa_pending_high", int'(res_high), 3);
    check("pa_pending_period", int'(res_period), 5);
    din = 1'b0; tick(); tick();
    din = 1'b1; tick();
    res_ready = 1'b1; tick();
    check("pa_valid", int'(res_valid), 1);
    check("pa_overrun", int'(overrun), 0);
    check("pa_high", int'(res_high), 2);
    check("pa_period", int'(res_period), 4);

    // Timeout: stuck high after a rise from ARM.
    din = 1'b0; meas_en = 1'b0; tick();
    meas_en = 1'b1; tick(); tick();
    pub_base = pub_cnt; to_base = to_cnt;
    din = 1'b1;
    repeat (65536) tick();
    check("to_before", int'(timeout), 0);
    tick();
    check("to_pulse", int'(timeout), 1);
    tick();
    check("to_after", int'(timeout), 0);
    repeat (70000 - 65538) tick();
    check("to_count", to_cnt - to_base, 1);
    check("to_no_pub", pub_cnt - pub_base, 0);
    din = 1'b0; tick(); tick();
    wave(5, 3, 1'b0, 0, 0);
    wave(5, 3, 1'b1, 5, 8);

    // Abort mid-low: pending result retained, nothing published.
    res_ready = 1'b0;
    wave(6, 2, 1'b0, 0, 0);
    meas_en = 1'b0; tick();
    din = 1'b1; tick(); tick();
    din = 1'b0; tick();
    check("abort_valid", int'(res_valid), 1);
    check("abort_high", int'(res_high), 5);
    check("abort_period", int'(res_period), 8);
    check("abort_overrun", int'(overrun), 0);

    // Reset in the middle of a high phase drops the pending result.
    meas_en = 1'b1; tick();
    din = 1'b0; tick();
    din = 1'b1; tick(); tick(); tick();
    check("midrst_pre_valid", int'(res_valid), 1);
    rst = 1'b1; tick();
    check_all_zero("midrst");
    rst = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
